pwm_sample_sched: RTL and testbench
===================================

// Module: pwm_sample_sched
// PURPOSE
// Sequences audio samples into the 8-bit PWM output stage. Buffers samples from the
// synth/mixer path in a small FIFO. Owns the PWM period counter and loads exactly one
// new sample at each period boundary. Handles priming, underrun and graceful stop.
// Sits between the voice mixer (valid/ready producer) and the PWM comparator
// (pwm_sample, pwm_count).
// PARAMETERS
// DEPTH       4        FIFO depth in samples (power of 2, >=2)
// PRIME_LEVEL 2        FIFO level needed before playback starts (1..DEPTH)
// PERIOD      256      clocks per PWM period (2..256); count runs 0..PERIOD-1
// MUTE_LEVEL  8'd128   silence code driven when not playing
// PORTS
// clk          in   1   system clock, all logic on rising edge
// n_rst        in   1   synchronous active-low reset
// en           in   1   playback enable
// in_sample    in   8   sample from mixer
// in_valid     in   1   in_sample valid
// in_ready     out  1   FIFO can accept; transfer when in_valid&&in_ready
// pwm_sample   out  8   duty value for PWM comparator (stable for a whole period)
// pwm_count    out  8   period counter for comparator (pwm_o = pwm_count < pwm_sample)
// period_start out  1   1-cycle pulse when pwm_count==0 and new pwm_sample valid (RUN)
// fifo_level   out  $clog2(DEPTH+1)  current FIFO occupancy
// underrun     out  1   1-cycle pulse: boundary reached with FIFO empty
// underrun_cnt out  8   saturating underrun count; cleared by reset or entering PRIME
// BEHAVIOUR
// Clock/reset: one clock `clk`. Reset is synchronous, active-low, on `n_rst`.
// Reset (n_rst=0 at edge): state=IDLE, FIFO empty, pwm_sample=MUTE_LEVEL, pwm_count=0,
//   in_ready=0, period_start=0, underrun=0, underrun_cnt=0, fifo_level=0.
//   Applies mid-period or mid-stream with no drain.
// States: IDLE, PRIME, RUN, STOP.
// - IDLE: in_ready=0, FIFO held empty, count held 0, pwm_sample=MUTE_LEVEL.
//   en=1 -> PRIME.
// - PRIME: in_ready=!full; count held 0; pwm_sample=MUTE_LEVEL; underrun_cnt cleared on entry.
//   en=0 -> IDLE (flush FIFO).
//   fifo_level>=PRIME_LEVEL (post-push value) -> RUN. On the first RUN cycle: count=0,
//   pwm_sample=popped head, period_start=1.
// - RUN: in_ready=!full; count increments each cycle.
//   At count==PERIOD-1 the next cycle has count=0 and period_start=1, and:
//     * FIFO non-empty: pop head into pwm_sample.
//     * FIFO empty: hold previous pwm_sample, underrun=1, underrun_cnt+=1 (sat 255).
//   en=0 -> STOP. The current period always completes.
// - STOP: in_ready=0; count continues to PERIOD-1; next cycle -> IDLE.
//   On entering IDLE: pwm_sample=MUTE_LEVEL, FIFO flushed.
// FIFO rules:
// - in_ready is derived from registered level only; no combinational path from pop.
//   A full FIFO does not accept, even on a pop cycle.
// - Push and pop in the same cycle: level unchanged; the pop takes the old head.
// - Push into an empty FIFO on a boundary cycle: underrun is reported. The pushed sample
//   is stored and used at the next boundary.
// - Pointers wrap mod DEPTH. Level is exact 0..DEPTH.
// Output timing and reset of outputs:
// - pwm_sample changes only on the period_start cycle.
// - Latency from first accepted sample to output is >= PRIME_LEVEL pushes + 1 clock.
// - All outputs are registered except in_ready (combinational from the state/level regs).
// TESTING (DEPTH=4, PRIME_LEVEL=2, PERIOD=8, MUTE_LEVEL=128)
// 1. Reset with en=1, in_valid=1:
//    -> pwm_sample=128, count=0, in_ready=0, level=0 for the cycle after reset.
// 2. en=1, push 10,20:
//    -> RUN next cycle, pwm_sample=10 with period_start;
//    -> 20 loads exactly 8 clocks later;
//    -> period_start every 8 clocks.
// 3. Stop pushing after 10,20:
//    -> third boundary: underrun pulse, pwm_sample stays 20, underrun_cnt=1;
//    -> 300 boundaries later underrun_cnt saturates at 255.
// 4. Hold in_valid=1 with values 1..9 during RUN:
//    -> in_ready drops at level=4;
//    -> accepted sequence appears in order with no loss or duplication.
// 5. Drop en at count=3:
//    -> count runs to 7; then IDLE, pwm_sample=128, level=0, in_ready=0.
// 6. Assert n_rst=0 mid-period (count=5) with level=3:
//    -> all outputs at reset values the next cycle;
//    -> re-prime is required before output resumes.

Source files
------------

// File: rtl/pwm_sample_sched.sv
// Audio sample scheduler for the 8-bit PWM stage: small sample FIFO, PWM period counter,
// one sample load per period boundary, with priming, underrun tracking and graceful stop.
module pwm_sample_sched #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PRIME_LEVEL = 2,
  parameter int unsigned PERIOD      = 256,
  parameter logic [7:0]  MUTE_LEVEL  = 8'd128
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         en,
  input  logic [7:0]                   in_sample,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [7:0]                   pwm_sample,
  output logic [7:0]                   pwm_count,
  output logic                         period_start,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         underrun,
  output logic [7:0]                   underrun_cnt
);

  localparam int unsigned LW        = $clog2(DEPTH + 1);
  localparam int unsigned PW        = $clog2(DEPTH);
  localparam logic [7:0]  LAST      = 8'(PERIOD - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, STOP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic          push, pop, flush;
  logic [7:0]    head;
  logic [LW-1:0] lvl_post;
  logic [7:0]    count_d, sample_d, ucnt_d;
  logic          pstart_d, under_d;

  // Ready depends only on registered state and level, never on this cycle's pop.
  assign in_ready = ((state_q == PRIME) || (state_q == RUN)) && (fifo_level != FULL_LVL);
  assign push     = in_valid && in_ready;
  assign lvl_post = fifo_level + LW'(push);
  // Bypass lets a sample pushed into an empty FIFO be taken in the same cycle.
  assign head     = (fifo_level == '0) ? in_sample : mem[rd_ptr_q];

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    count_d  = pwm_count;
    sample_d = pwm_sample;
    pstart_d = 1'b0;
    under_d  = 1'b0;
    ucnt_d   = underrun_cnt;
    pop      = 1'b0;
    flush    = 1'b0;
    unique case (state_q)
      IDLE: begin
        flush    = 1'b1;
        count_d  = '0;
        sample_d = MUTE_LEVEL;
        if (en) begin
          state_d = PRIME;
          ucnt_d  = '0;
        end
      end
      PRIME: begin
        count_d  = '0;
        sample_d = MUTE_LEVEL;
        if (!en) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else if (lvl_post >= PRIME_LVL) begin
          state_d  = RUN;
          pop      = 1'b1;
          sample_d = head;
          pstart_d = 1'b1;
        end
      end
      RUN: begin
        if (pwm_count == LAST) begin
          count_d = '0;
          if (!en) begin
            // Period just completed, so stop goes straight to idle.
            state_d  = IDLE;
            flush    = 1'b1;
            sample_d = MUTE_LEVEL;
          end else begin
            pstart_d = 1'b1;
            if (fifo_level != '0) begin
              pop      = 1'b1;
              sample_d = mem[rd_ptr_q];
            end else begin
              under_d = 1'b1;
              if (underrun_cnt != 8'hFF) ucnt_d = underrun_cnt + 8'd1;
            end
          end
        end else begin
          count_d = pwm_count + 8'd1;
          if (!en) state_d = STOP;
        end
      end
      STOP: begin
        if (pwm_count == LAST) begin
          state_d  = IDLE;
          count_d  = '0;
          flush    = 1'b1;
          sample_d = MUTE_LEVEL;
        end else begin
          count_d = pwm_count + 8'd1;
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      pwm_count    <= '0;
      pwm_sample   <= MUTE_LEVEL;
      period_start <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state_q      <= state_d;
      pwm_count    <= count_d;
      pwm_sample   <= sample_d;
      period_start <= pstart_d;
      underrun     <= under_d;
      underrun_cnt <= ucnt_d;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!n_rst || flush) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_sample;
  end

endmodule

// File: tb/tb_pwm_sample_sched.sv
// Bench for pwm_sample_sched: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pwm_sample_sched;
  localparam int DEPTH = 4;
  localparam int PLVL  = 2;
  localparam int PER   = 8;
  localparam int MUTE  = 128;

  logic       clk = 1'b0;
  logic       n_rst, en, in_valid, in_ready, period_start, underrun;
  logic [7:0] in_sample, pwm_sample, pwm_count, underrun_cnt;
  logic [2:0] fifo_level;

  int errors = 0;
  int checks = 0;

  pwm_sample_sched #(
    .DEPTH(4), .PRIME_LEVEL(2), .PERIOD(8), .MUTE_LEVEL(8'd128)
  ) dut (
    .clk(clk), .n_rst(n_rst), .en(en), .in_sample(in_sample), .in_valid(in_valid),
    .in_ready(in_ready), .pwm_sample(pwm_sample), .pwm_count(pwm_count),
    .period_start(period_start), .fifo_level(fifo_level), .underrun(underrun),
    .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: playback mode, sample queue, period position.
  typedef enum int {M_IDLE, M_PRIME, M_RUN, M_STOP} mmode_t;
  mmode_t     m_mode = M_IDLE;
  logic [7:0] q[$];
  int         m_cnt  = 0;
  int         m_ucnt = 0;
  int         m_samp = MUTE;
  int         m_ps   = 0;
  int         m_ur   = 0;
  bit         chk_on = 0;
  bit         saw_full = 0;
  logic [7:0] loads[$];

  function automatic int m_ready();
    return ((m_mode == M_PRIME || m_mode == M_RUN) && q.size() < DEPTH) ? 1 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int push;
    push = (in_valid === 1'b1 && m_ready() == 1) ? 1 : 0;
    m_ps = 0;
    m_ur = 0;
    if (n_rst !== 1'b1) begin
      m_mode = M_IDLE; q.delete(); m_cnt = 0; m_ucnt = 0; m_samp = MUTE;
    end else begin
      case (m_mode)
        M_IDLE: begin
          q.delete(); m_cnt = 0; m_samp = MUTE;
          if (en) begin m_mode = M_PRIME; m_ucnt = 0; end
        end
        M_PRIME: begin
          if (!en) begin
            m_mode = M_IDLE; q.delete();
          end else begin
            if (push == 1) q.push_back(in_sample);
            if (q.size() >= PLVL) begin
              m_mode = M_RUN; m_samp = q.pop_front(); m_ps = 1; m_cnt = 0;
            end
          end
        end
        M_RUN: begin
          if (m_cnt == PER - 1) begin
            m_cnt = 0;
            if (!en) begin
              m_mode = M_IDLE; q.delete(); m_samp = MUTE;
            end else begin
              m_ps = 1;
              // Boundary takes the old head before any same-cycle push lands.
              if (q.size() > 0) m_samp = q.pop_front();
              else begin m_ur = 1; if (m_ucnt < 255) m_ucnt++; end
              if (push == 1) q.push_back(in_sample);
            end
          end else begin
            m_cnt++;
            if (push == 1) q.push_back(in_sample);
            if (!en) m_mode = M_STOP;
          end
        end
        M_STOP: begin
          if (m_cnt == PER - 1) begin
            m_mode = M_IDLE; q.delete(); m_samp = MUTE; m_cnt = 0;
          end else m_cnt++;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("pwm_sample", pwm_sample, m_samp);
      check("pwm_count", pwm_count, m_cnt);
      check("period_start", period_start, m_ps);
      check("underrun", underrun, m_ur);
      check("underrun_cnt", underrun_cnt, m_ucnt);
      check("fifo_level", fifo_level, q.size());
      check("in_ready", in_ready, m_ready());
      if (fifo_level == 3'd4 && in_ready == 1'b0) saw_full = 1;
      if (period_start === 1'b1 && underrun === 1'b0) loads.push_back(pwm_sample);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input int target);
    int b;
    b = 0;
    while (pwm_count != 8'(target) && b < 40) begin step(); b++; end
    check("wait_count_timeout", (pwm_count == 8'(target)) ? 1 : 0, 1);
  endtask

  initial begin
    logic [7:0] exp_loads[11];
    n_rst = 1'b0; en = 1'b1; in_valid = 1'b1; in_sample = 8'd55;
    step(); step();
    chk_on = 1;
    check("rst_sample", pwm_sample, MUTE);
    check("rst_count", pwm_count, 0);
    check("rst_ready", in_ready, 0);
    check("rst_level", fifo_level, 0);
    n_rst = 1'b1; en = 1'b0; in_valid = 1'b0;
    step();

    // Prime with 10,20 and run dry.
    loads.delete();
    en = 1'b1; step();
    in_valid = 1'b1; in_sample = 8'd10; step();
    in_sample = 8'd20; step();
    in_valid = 1'b0;
    check("first_sample", pwm_sample, 10);
    check("first_pstart", period_start, 1);
    check("first_count", pwm_count, 0);
    repeat (PER) step();
    check("second_sample", pwm_sample, 20);
    check("second_pstart", period_start, 1);
    repeat (PER) step();
    check("underrun_pulse", underrun, 1);
    check("underrun_hold", pwm_sample, 20);
    check("underrun_cnt1", underrun_cnt, 1);
    repeat (300 * PER) step();
    check("underrun_sat", underrun_cnt, 255);

    // Burst 1..9 against backpressure.
    for (int k = 1; k <= 9; k++) begin
      int  b;
      bit  acc;
      in_valid = 1'b1; in_sample = 8'(k); acc = 0; b = 0;
      while (!acc && b < 60) begin acc = in_ready; step(); b++; end
      check("burst_accept_timeout", acc, 1);
    end
    in_valid = 1'b0;
    begin
      int b;
      b = 0;
      while (loads.size() < 11 && b < 200) begin step(); b++; end
    end
    check("saw_full", saw_full, 1);
    check("loads_count", loads.size(), 11);
    exp_loads[0] = 8'd10; exp_loads[1] = 8'd20;
    for (int k = 1; k <= 9; k++) exp_loads[k+1] = 8'(k);
    for (int i = 0; i < 11 && i < loads.size(); i++) check("load_order", loads[i], exp_loads[i]);

    // Stop requested mid-period.
    wait_count(3);
    en = 1'b0;
    repeat (4) step();
    check("stop_count7", pwm_count, 7);
    step();
    check("stop_sample", pwm_sample, MUTE);
    check("stop_level", fifo_level, 0);
    check("stop_ready", in_ready, 0);
    check("stop_count0", pwm_count, 0);

    // Reset mid-period with a partly full FIFO.
    en = 1'b1; step();
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin in_sample = 8'(40 + k); step(); end
    in_valid = 1'b0;
    wait_count(5);
    check("pre_rst_level", fifo_level, 3);
    n_rst = 1'b0; step();
    check("mid_rst_sample", pwm_sample, MUTE);
    check("mid_rst_count", pwm_count, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_ready", in_ready, 0);
    n_rst = 1'b1;
    repeat (20) step();
    check("reprime_sample", pwm_sample, MUTE);
    check("reprime_count", pwm_count, 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 3) en = ~en;
      n_rst     = ($urandom_range(0, 599) != 0);
      in_valid  = ($urandom_range(0, 99) < ((i < 2000) ? 30 : 12));
      in_sample = 8'($urandom);
      step();
    end
    n_rst = 1'b1; in_valid = 1'b0;
    step();

    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
